mvm_sequencer: RTL and testbench
================================

Name: mvm_sequencer

Overview:
Controller that sequences the dot-product engine (dpe) to compute a matrix-vector product whose row length is NUM_CHUNKS x (DATAW/8) 8-bit elements.
- Loads the vector as NUM_CHUNKS DATAW-bit beats into an internal register bank.
- Streams matrix rows in through a valid/ready port and issues one dpe operation per matrix beat, pairing it with the matching vector chunk.
- Accumulates the NUM_CHUNKS dpe partial results for each row and emits one row sum per row.
- Sits between the host/DMA stream logic and a single dpe instance.

Parameters:
DATAW, 512, width of vector/matrix beats and dpe operands
OPREC, 32, dpe result width
NUM_CHUNKS, 4, dpe beats per matrix row (>=1)
ROWW, 16, row-count and row-index width
ACCW, OPREC+$clog2(NUM_CHUNKS), row-sum width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_start  in  1  begin job; sampled only in IDLE
i_num_rows  in  ROWW  rows in job, captured with i_start
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse at job completion
i_vec_valid  in  1  vector beat valid
i_vec_data  in  DATAW  vector chunk, chunk 0 first
o_vec_ready  out  1  vector beat accepted when valid&ready
i_mat_valid  in  1  matrix beat valid
i_mat_data  in  DATAW  matrix beat, row-major, chunk 0 first
o_mat_ready  out  1  matrix beat accepted when valid&ready
o_dpe_valid  out  1  to dpe i_valid
o_dpe_dataa  out  DATAW  to dpe i_dataa (matrix beat)
o_dpe_datab  out  DATAW  to dpe i_datab (vector chunk)
i_dpe_valid  in  1  from dpe o_valid
i_dpe_result  in  OPREC  from dpe o_result
o_res_valid  out  1  row sum valid, one cycle per row
o_res_data  out  ACCW  row sum
o_res_row  out  ROWW  row index of o_res_data, 0-based

Behaviour:
- Reset: state IDLE. o_busy, o_done, o_vec_ready, o_mat_ready, o_dpe_valid, o_res_valid are 0. o_dpe_dataa, o_dpe_datab, o_res_data, o_res_row are 0. All counters and the accumulator are 0. Reset mid-job aborts the job; the vector bank is not cleared.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - i_start with i_num_rows==0: o_done pulses the next cycle; stays IDLE; no vector load.
  - i_start with i_num_rows!=0: captures the row count and goes to LOAD.
  - i_start in any other state is ignored.
- LOAD:
  - o_vec_ready=1. Each accepted beat writes bank[vec_idx], then vec_idx increments.
  - On acceptance of chunk NUM_CHUNKS-1: vec_idx returns to 0 and the state goes to RUN.
- RUN:
  - o_mat_ready=1, combinational on state only.
  - Each accepted beat registers o_dpe_valid=1, o_dpe_dataa=i_mat_data and o_dpe_datab=bank[chunk_idx], visible the next cycle. o_dpe_valid=0 on cycles with no acceptance; operand registers hold their values.
  - chunk_idx wraps NUM_CHUNKS-1 -> 0 and increments issue_row on the wrap.
  - Acceptance of the last chunk of the last row goes to DRAIN; o_mat_ready=0 from that next cycle.
- Result side, independent of issue; dpe latency is not assumed:
  - Counts res_chunk and res_row. Each i_dpe_valid in RUN or DRAIN updates acc: acc <= (res_chunk==0) ? zext(result) : acc+zext(result).
  - When res_chunk==NUM_CHUNKS-1: o_res_valid=1 next cycle with o_res_data=acc+result (or zext(result) if NUM_CHUNKS==1) and o_res_row=res_row. res_chunk then wraps and res_row increments.
  - Arithmetic is unsigned, modulo 2^ACCW. ACCW cannot overflow for unsigned OPREC inputs.
  - i_dpe_valid in IDLE or LOAD is ignored; this covers stale dpe results after reset.
- DRAIN: once the last row sum is emitted (o_res_valid cycle), o_done pulses the following cycle and the state goes to IDLE. o_busy=0 in the o_done cycle.
- No backpressure on o_res_*; the consumer must always accept.
- Simultaneous issue and return in the same cycle are both handled.
- Rows issued minus rows completed is unbounded; counters are ROWW bits.

Test Plan:
1. Reset; i_start, i_num_rows=2; 4 vector beats, all bytes 1; 8 matrix beats, all bytes 1; real dpe -> four dpe results of 64 per row. o_res_valid twice: data 256, rows 0 then 1. o_done exactly one cycle after the second o_res_valid.
2. Vector chunk k bytes = k+1, matrix bytes 1, num_rows=1 -> o_dpe_datab follows the chunk order. Dpe results 64, 128, 192, 256; o_res_data=640.
3. i_mat_valid toggled pseudo-randomly with num_rows=3 -> o_dpe_valid count equals accepted beats (12). Sums are identical to the no-gap run. o_mat_ready=0 after the 12th beat.
4. num_rows=0 -> o_done the next cycle; o_vec_ready never asserts; o_busy stays 0.
5. Behavioural dpe model returning 0xFFFFFFFF with latency 7 -> o_res_data=0x3FFFFFFFC (34-bit). A second i_start during RUN is ignored.
6. rst asserted mid-RUN for one cycle -> the next cycle all outputs are 0 and the state is IDLE. Late i_dpe_valid pulses produce no o_res_valid. A fresh job (scenario 1) then passes.

Source files
------------

// File: rtl/mvm_sequencer_if.sv
// Host, vector/matrix stream, dpe and result signals of the matrix-vector sequencer.
// The sequencer uses the slave view; the host/dpe side uses the master view.
interface mvm_sequencer_if #(
  parameter int DATAW      = 512,
  parameter int OPREC      = 32,
  parameter int NUM_CHUNKS = 4,
  parameter int ROWW       = 16
);
  localparam int ACCW = OPREC + $clog2(NUM_CHUNKS);

  logic              i_start;
  logic [ROWW-1:0]   i_num_rows;
  logic              o_busy;
  logic              o_done;
  logic              i_vec_valid;
  logic [DATAW-1:0]  i_vec_data;
  logic              o_vec_ready;
  logic              i_mat_valid;
  logic [DATAW-1:0]  i_mat_data;
  logic              o_mat_ready;
  logic              o_dpe_valid;
  logic [DATAW-1:0]  o_dpe_dataa;
  logic [DATAW-1:0]  o_dpe_datab;
  logic              i_dpe_valid;
  logic [OPREC-1:0]  i_dpe_result;
  logic              o_res_valid;
  logic [ACCW-1:0]   o_res_data;
  logic [ROWW-1:0]   o_res_row;

  modport slave (
    input  i_start, i_num_rows, i_vec_valid, i_vec_data, i_mat_valid, i_mat_data,
           i_dpe_valid, i_dpe_result,
    output o_busy, o_done, o_vec_ready, o_mat_ready, o_dpe_valid, o_dpe_dataa,
           o_dpe_datab, o_res_valid, o_res_data, o_res_row
  );

  modport master (
    output i_start, i_num_rows, i_vec_valid, i_vec_data, i_mat_valid, i_mat_data,
           i_dpe_valid, i_dpe_result,
    input  o_busy, o_done, o_vec_ready, o_mat_ready, o_dpe_valid, o_dpe_dataa,
           o_dpe_datab, o_res_valid, o_res_data, o_res_row
  );
endinterface

// File: rtl/mvm_sequencer.sv
// Sequences a dot-product engine over NUM_CHUNKS-beat matrix rows against a stored
// vector and accumulates the partial results into one row sum per row.
module mvm_sequencer #(
  parameter int DATAW      = 512,
  parameter int OPREC      = 32,
  parameter int NUM_CHUNKS = 4,
  parameter int ROWW       = 16
) (
  input  logic         clk,
  input  logic         rst,
  mvm_sequencer_if.slave bus
);
  localparam int ACCW = OPREC + $clog2(NUM_CHUNKS);
  localparam int CW   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t           state_q;
  logic [ROWW-1:0]  num_rows_q;
  logic [ROWW-1:0]  issue_row_q;
  logic [ROWW-1:0]  res_row_q;
  logic [CW-1:0]    vec_idx_q;
  logic [CW-1:0]    chunk_idx_q;
  logic [CW-1:0]    res_chunk_q;
  logic [ACCW-1:0]  acc_q;
  logic [DATAW-1:0] bank_q [NUM_CHUNKS];

  logic             done_q;
  logic             dpe_valid_q;
  logic [DATAW-1:0] dpe_dataa_q;
  logic [DATAW-1:0] dpe_datab_q;
  logic             res_valid_q;
  logic [ACCW-1:0]  res_data_q;
  logic [ROWW-1:0]  res_row_out_q;

  logic             vec_fire;
  logic             mat_fire;
  logic             dpe_fire;
  logic [ACCW-1:0]  acc_d;

  assign vec_fire = (state_q == LOAD) && bus.i_vec_valid;
  assign mat_fire = (state_q == RUN) && bus.i_mat_valid;
  // Results outside RUN/DRAIN are stale (e.g. in flight across a reset) and dropped.
  assign dpe_fire = ((state_q == RUN) || (state_q == DRAIN)) && bus.i_dpe_valid;
  assign acc_d    = (res_chunk_q == '0) ? ACCW'(bus.i_dpe_result)
                                        : acc_q + ACCW'(bus.i_dpe_result);

  // Vector bank has no reset so it survives an aborted job.
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_bank
    always_ff @(posedge clk) begin
      if (vec_fire && (vec_idx_q == CW'(gi))) begin
        bank_q[gi] <= bus.i_vec_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      num_rows_q    <= '0;
      issue_row_q   <= '0;
      res_row_q     <= '0;
      vec_idx_q     <= '0;
      chunk_idx_q   <= '0;
      res_chunk_q   <= '0;
      acc_q         <= '0;
      done_q        <= 1'b0;
      dpe_valid_q   <= 1'b0;
      dpe_dataa_q   <= '0;
      dpe_datab_q   <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_row_out_q <= '0;
    end else begin
      done_q      <= 1'b0;
      dpe_valid_q <= 1'b0;
      res_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            if (bus.i_num_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              num_rows_q  <= bus.i_num_rows;
              issue_row_q <= '0;
              res_row_q   <= '0;
              vec_idx_q   <= '0;
              chunk_idx_q <= '0;
              res_chunk_q <= '0;
              acc_q       <= '0;
              state_q     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (vec_fire) begin
            if (vec_idx_q == LAST_CHUNK) begin
              vec_idx_q <= '0;
              state_q   <= RUN;
            end else begin
              vec_idx_q <= vec_idx_q + CW'(1);
            end
          end
        end
        RUN: begin
          if (mat_fire) begin
            dpe_valid_q <= 1'b1;
            dpe_dataa_q <= bus.i_mat_data;
            dpe_datab_q <= bank_q[chunk_idx_q];
            if (chunk_idx_q == LAST_CHUNK) begin
              chunk_idx_q <= '0;
              issue_row_q <= issue_row_q + ROWW'(1);
              if (issue_row_q == num_rows_q - ROWW'(1)) begin
                state_q <= DRAIN;
              end
            end else begin
              chunk_idx_q <= chunk_idx_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          // res_row_q has already advanced past the row being emitted.
          if (res_valid_q && (res_row_q == num_rows_q)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (dpe_fire) begin
        acc_q <= acc_d;
        if (res_chunk_q == LAST_CHUNK) begin
          res_valid_q   <= 1'b1;
          res_data_q    <= acc_d;
          res_row_out_q <= res_row_q;
          res_chunk_q   <= '0;
          res_row_q     <= res_row_q + ROWW'(1);
        end else begin
          res_chunk_q <= res_chunk_q + CW'(1);
        end
      end
    end
  end

  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_done      = done_q;
  assign bus.o_vec_ready = (state_q == LOAD);
  assign bus.o_mat_ready = (state_q == RUN);
  assign bus.o_dpe_valid = dpe_valid_q;
  assign bus.o_dpe_dataa = dpe_dataa_q;
  assign bus.o_dpe_datab = dpe_datab_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_res_row   = res_row_out_q;
endmodule

// File: tb/tb_mvm_sequencer.sv
// Scoreboard bench for mvm_sequencer with a behavioural dot-product engine of
// programmable latency; row sums are predicted when matrix beats are accepted.
module tb_mvm_sequencer;
  localparam int DATAW      = 512;
  localparam int OPREC      = 32;
  localparam int NUM_CHUNKS = 4;
  localparam int ROWW       = 16;
  localparam int ACCW       = OPREC + $clog2(NUM_CHUNKS);
  localparam int NB         = DATAW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mvm_sequencer_if #(.DATAW(DATAW), .OPREC(OPREC), .NUM_CHUNKS(NUM_CHUNKS), .ROWW(ROWW)) bus();

  mvm_sequencer #(.DATAW(DATAW), .OPREC(OPREC), .NUM_CHUNKS(NUM_CHUNKS), .ROWW(ROWW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural dpe: unsigned byte-wise dot product, delayed by dpe_lat cycles.
  int               dpe_lat   = 2;
  bit               dpe_force = 1'b0;
  logic [OPREC-1:0] dpe_const = '0;
  logic             inj_valid = 1'b0;
  logic [7:0]       pv = '0;
  logic [OPREC-1:0] pr [8];

  function automatic logic [OPREC-1:0] dot(input logic [DATAW-1:0] a, input logic [DATAW-1:0] b);
    logic [OPREC-1:0] s = '0;
    for (int i = 0; i < NB; i++) s += OPREC'(a[8*i +: 8]) * OPREC'(b[8*i +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[6:0], bus.o_dpe_valid};
    pr[0] <= dpe_force ? dpe_const : dot(bus.o_dpe_dataa, bus.o_dpe_datab);
    for (int i = 1; i < 8; i++) pr[i] <= pr[i-1];
  end

  assign bus.i_dpe_valid  = pv[dpe_lat-1] | inj_valid;
  assign bus.i_dpe_result = pr[dpe_lat-1];

  logic [DATAW-1:0] vec_mem [NUM_CHUNKS];
  logic [DATAW-1:0] mat_mem [16];

  // Scoreboard and monitor state
  logic [ACCW-1:0]  exp_data_q [$];
  logic [ROWW-1:0]  exp_row_q  [$];
  logic [DATAW-1:0] datab_log  [$];
  logic [ACCW-1:0]  last_res_data;
  int cyc = 0;
  int res_cnt, dpe_cnt, done_cnt, last_res_cyc, done_cyc;
  bit vec_ready_seen, busy_seen;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    logic [ACCW-1:0] ed;
    logic [ROWW-1:0] er;
    forever begin
      @(negedge clk);
      if (bus.o_res_valid === 1'b1) begin
        res_cnt++;
        last_res_cyc  = cyc;
        last_res_data = bus.o_res_data;
        total++;
        if (exp_data_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got data=%0h row=%0d, required no result",
                   bus.o_res_data, bus.o_res_row);
        end else begin
          ed = exp_data_q.pop_front();
          er = exp_row_q.pop_front();
          if (bus.o_res_data !== ed || bus.o_res_row !== er) begin
            bad++;
            $display("FAIL row_sum: got data=%0h row=%0d, required data=%0h row=%0d",
                     bus.o_res_data, bus.o_res_row, ed, er);
          end
        end
      end
      if (bus.o_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.o_dpe_valid === 1'b1) begin
        dpe_cnt++;
        datab_log.push_back(bus.o_dpe_datab);
      end
      if (bus.o_vec_ready === 1'b1) vec_ready_seen = 1'b1;
      if (bus.o_busy === 1'b1) busy_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required job completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    res_cnt = 0; dpe_cnt = 0; done_cnt = 0;
    vec_ready_seen = 1'b0; busy_seen = 1'b0;
    datab_log.delete();
  endtask

  // mode 0: all vector bytes 1; mode 1: chunk k bytes k+1. Matrix bytes always 1.
  task automatic fill(input int mode);
    logic [DATAW-1:0] v;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      for (int b = 0; b < NB; b++) v[8*b +: 8] = (mode == 1) ? 8'(k + 1) : 8'd1;
      vec_mem[k] = v;
    end
    for (int b = 0; b < NB; b++) v[8*b +: 8] = 8'd1;
    for (int i = 0; i < 16; i++) mat_mem[i] = v;
  endtask

  task automatic start_job(input int rows);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_num_rows = ROWW'(rows);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic load_vec();
    int k = 0;
    int budget = 200;
    while (k < NUM_CHUNKS && budget > 0) begin
      if (k > 0 || budget < 200) @(negedge clk);
      bus.i_vec_valid = 1'b1;
      bus.i_vec_data  = vec_mem[k];
      if (bus.o_vec_ready === 1'b1) k++;
      budget--;
    end
    @(negedge clk);
    bus.i_vec_valid = 1'b0;
    total++;
    if (k != NUM_CHUNKS) begin
      bad++;
      $display("FAIL vec_load: accepted %0d beats, required %0d", k, NUM_CHUNKS);
    end
  endtask

  // Sends nbeats matrix beats; optionally holds i_start high while beat start_at is offered.
  task automatic send_mat(input int nbeats, input bit gaps, input int start_at);
    int idx = 0;
    int budget = 2000;
    bit v;
    logic [ACCW-1:0] row_acc = '0;
    while (idx < nbeats && budget > 0) begin
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.i_mat_valid = v;
      bus.i_mat_data  = mat_mem[idx];
      bus.i_start     = (idx == start_at);
      bus.i_num_rows  = ROWW'(5);
      if (v && bus.o_mat_ready === 1'b1) begin
        row_acc += ACCW'(dpe_force ? dpe_const : dot(mat_mem[idx], vec_mem[idx % NUM_CHUNKS]));
        if (idx % NUM_CHUNKS == NUM_CHUNKS - 1) begin
          exp_data_q.push_back(row_acc);
          exp_row_q.push_back(ROWW'(idx / NUM_CHUNKS));
          row_acc = '0;
        end
        idx++;
      end
      budget--;
      @(negedge clk);
    end
    bus.i_mat_valid = 1'b0;
    bus.i_start     = 1'b0;
    total++;
    if (idx != nbeats) begin
      bad++;
      $display("FAIL mat_send: accepted %0d beats, required %0d", idx, nbeats);
    end
  endtask

  task automatic wait_done(input int rows, input string name);
    int budget = 500;
    while (done_cnt == 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done: got done count=%0d, required 1 (timeout bound 500)", name, done_cnt);
    end
    total++;
    if (res_cnt != rows || exp_data_q.size() != 0) begin
      bad++;
      $display("FAIL %s_rows: got %0d row sums, %0d still expected, required %0d and 0",
               name, res_cnt, exp_data_q.size(), rows);
    end
    total++;
    if (done_cyc != last_res_cyc + 1) begin
      bad++;
      $display("FAIL %s_done_timing: got done at cycle %0d, required %0d",
               name, done_cyc, last_res_cyc + 1);
    end
    total++;
    if (bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_at_done: got %b, required 0", name, bus.o_busy);
    end
  endtask

  task automatic run_job(input int rows, input bit gaps, input int start_at, input string name);
    clear_stats();
    start_job(rows);
    load_vec();
    send_mat(rows * NUM_CHUNKS, gaps, start_at);
    wait_done(rows, name);
  endtask

  task automatic test_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus.o_busy, bus.o_done, bus.o_vec_ready, bus.o_mat_ready, bus.o_dpe_valid,
         bus.o_res_valid} !== 6'b0) begin
      bad++;
      $display("FAIL %s_flags: got busy,done,vrdy,mrdy,dpev,resv=%b, required 000000", name,
               {bus.o_busy, bus.o_done, bus.o_vec_ready, bus.o_mat_ready, bus.o_dpe_valid,
                bus.o_res_valid});
    end
    total++;
    if (bus.o_dpe_dataa !== '0 || bus.o_dpe_datab !== '0) begin
      bad++;
      $display("FAIL %s_operands: got nonzero dpe operands, required 0", name);
    end
    total++;
    if (bus.o_res_data !== '0 || bus.o_res_row !== '0) begin
      bad++;
      $display("FAIL %s_result: got data=%0h row=%0d, required 0 and 0", name,
               bus.o_res_data, bus.o_res_row);
    end
  endtask

  task automatic test_basic();
    fill(0);
    dpe_lat = 2;
    run_job(2, 1'b0, -1, "basic");
    total++;
    if (last_res_data !== ACCW'(256)) begin
      bad++;
      $display("FAIL basic_sum: got %0d, required 256", last_res_data);
    end
  endtask

  task automatic test_chunk_order();
    fill(1);
    dpe_lat = 1;
    run_job(1, 1'b0, -1, "order");
    total++;
    if (datab_log.size() != NUM_CHUNKS) begin
      bad++;
      $display("FAIL order_count: got %0d dpe ops, required %0d", datab_log.size(), NUM_CHUNKS);
    end else begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        total++;
        if (datab_log[k] !== vec_mem[k]) begin
          bad++;
          $display("FAIL order_datab%0d: got byte0=%0d, required %0d", k, datab_log[k][7:0], k + 1);
        end
      end
    end
    total++;
    if (last_res_data !== ACCW'(640)) begin
      bad++;
      $display("FAIL order_sum: got %0d, required 640", last_res_data);
    end
  endtask

  task automatic test_gaps();
    fill(0);
    dpe_lat = 3;
    clear_stats();
    start_job(3);
    load_vec();
    send_mat(12, 1'b1, -1);
    total++;
    if (bus.o_mat_ready !== 1'b0) begin
      bad++;
      $display("FAIL gaps_ready: got o_mat_ready=%b after last beat, required 0", bus.o_mat_ready);
    end
    wait_done(3, "gaps");
    total++;
    if (dpe_cnt != 12) begin
      bad++;
      $display("FAIL gaps_dpe_count: got %0d, required 12", dpe_cnt);
    end
  endtask

  task automatic test_zero_rows();
    clear_stats();
    start_job(0);
    total++;
    if (bus.o_done !== 1'b1) begin
      bad++;
      $display("FAIL zero_done: got %b, required 1", bus.o_done);
    end
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt != 1 || vec_ready_seen || busy_seen) begin
      bad++;
      $display("FAIL zero_quiet: got done=%0d vec_ready_seen=%0d busy_seen=%0d, required 1 0 0",
               done_cnt, vec_ready_seen, busy_seen);
    end
  endtask

  task automatic test_max_result();
    fill(0);
    dpe_lat   = 7;
    dpe_force = 1'b1;
    dpe_const = 32'hFFFF_FFFF;
    run_job(1, 1'b0, 2, "maxres");
    total++;
    if (last_res_data !== 34'h3_FFFF_FFFC) begin
      bad++;
      $display("FAIL maxres_sum: got %0h, required 3fffffffc", last_res_data);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.o_busy !== 1'b0 || res_cnt != 1) begin
      bad++;
      $display("FAIL maxres_restart: got busy=%b rows=%0d, required 0 and 1", bus.o_busy, res_cnt);
    end
    dpe_force = 1'b0;
  endtask

  task automatic test_abort();
    fill(0);
    dpe_lat = 3;
    clear_stats();
    start_job(2);
    load_vec();
    send_mat(3, 1'b0, -1);
    test_reset("abort");
    inj_valid = 1'b1;
    repeat (4) @(negedge clk);
    inj_valid = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (res_cnt != 0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_stale: got %0d row sums busy=%b, required 0 and 0", res_cnt, bus.o_busy);
    end
    test_basic();
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_num_rows = '0;
    bus.i_vec_valid = 1'b0; bus.i_vec_data = '0;
    bus.i_mat_valid = 1'b0; bus.i_mat_data = '0;
    clear_stats();
    test_reset("reset");
    test_basic();
    test_chunk_order();
    test_gaps();
    test_zero_rows();
    test_max_result();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
